// File: rtl/ad9122_tx_sequencer_if.sv
// Handshake/data bundle between the TX DSP chain, the sequencer and the DDR/LVDS stage.
// The slave modport is the sequencer's view; the master modport is the driving side.
interface ad9122_tx_sequencer_if #(
    parameter int WIDTH = 16
);
    logic             enable;
    logic             resync;
    logic [WIDTH-1:0] tx_i;
    logic [WIDTH-1:0] tx_q;
    logic             tx_strobe;
    logic             test_mode;
    logic [WIDTH-1:0] dac_a;
    logic [WIDTH-1:0] dac_b;
    logic             frame_d1;
    logic             frame_d2;
    logic             running;
    logic [15:0]      underrun_cnt;

    modport master (
        output enable, resync, tx_i, tx_q, tx_strobe, test_mode,
        input  dac_a, dac_b, frame_d1, frame_d2, running, underrun_cnt
    );

    modport slave (
        input  enable, resync, tx_i, tx_q, tx_strobe, test_mode,
        output dac_a, dac_b, frame_d1, frame_d2, running, underrun_cnt
    );
endinterface

// File: rtl/ad9122_tx_sequencer.sv
// AD9122 TX sequencer: midscale settle, FRAME pulse to reset the DAC FIFO, then I/Q streaming with underrun count.
// Optional ramp test source built in with `define AD9122_TESTPAT_EN (test_mode selects it during RUN).
module ad9122_tx_sequencer #(
    parameter int WIDTH         = 16,
    parameter int SETTLE_CYCLES = 64,
    parameter int FRAME_CYCLES  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    ad9122_tx_sequencer_if.slave         bus
);
    typedef enum logic [1:0] {IDLE, SETTLE, FRAME, RUN} state_t;

    localparam logic [15:0] SETTLE_LOAD = 16'(SETTLE_CYCLES - 1);
    localparam logic [15:0] FRAME_LOAD  = 16'(FRAME_CYCLES - 1);

    state_t           state_q, state_d;
    logic [15:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0] dac_a_q, dac_a_d;
    logic [WIDTH-1:0] dac_b_q, dac_b_d;
    logic             frame_q, frame_d;
    logic             running_q, running_d;
    logic [15:0]      underrun_q, underrun_d;
    logic             test_active;

`ifdef AD9122_TESTPAT_EN
    logic [WIDTH-1:0] ramp_q, ramp_d;
    logic             settle_entry;
`else
    logic             unused_test_mode;
    assign unused_test_mode = bus.test_mode;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!bus.enable) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = SETTLE;
                    cnt_d   = SETTLE_LOAD;
                end
                SETTLE: begin
                    if (bus.resync) begin
                        cnt_d = SETTLE_LOAD;
                    end else if (cnt_q == 16'd0) begin
                        state_d = FRAME;
                        cnt_d   = FRAME_LOAD;
                    end else begin
                        cnt_d = cnt_q - 16'd1;
                    end
                end
                FRAME: begin
                    if (bus.resync) begin
                        state_d = SETTLE;
                        cnt_d   = SETTLE_LOAD;
                    end else if (cnt_q == 16'd0) begin
                        state_d = RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - 16'd1;
                    end
                end
                RUN: begin
                    if (bus.resync) begin
                        state_d = SETTLE;
                        cnt_d   = SETTLE_LOAD;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Output flops follow the next state so each indicator lines up with the state it reports.
    always_comb begin
        frame_d    = (state_d == FRAME);
        running_d  = (state_d == RUN);
        dac_a_d    = '0;
        dac_b_d    = '0;
        underrun_d = underrun_q;
`ifdef AD9122_TESTPAT_EN
        test_active  = bus.test_mode;
        settle_entry = (state_d == SETTLE) && ((state_q != SETTLE) || bus.resync);
        ramp_d       = ramp_q;
        if (settle_entry) begin
            ramp_d = '0;
        end else if (state_d == RUN) begin
            ramp_d = ramp_q + 1'b1;
        end
`else
        test_active = 1'b0;
`endif
        if (state_d == RUN) begin
            if (test_active) begin
`ifdef AD9122_TESTPAT_EN
                dac_a_d = ramp_q;
                dac_b_d = ~ramp_q;
`endif
            end else if (bus.tx_strobe) begin
                dac_a_d = bus.tx_i;
                dac_b_d = bus.tx_q;
            end else if (underrun_q != 16'hFFFF) begin
                underrun_d = underrun_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            dac_a_q    <= '0;
            dac_b_q    <= '0;
            frame_q    <= 1'b0;
            running_q  <= 1'b0;
            underrun_q <= '0;
`ifdef AD9122_TESTPAT_EN
            ramp_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dac_a_q    <= dac_a_d;
            dac_b_q    <= dac_b_d;
            frame_q    <= frame_d;
            running_q  <= running_d;
            underrun_q <= underrun_d;
`ifdef AD9122_TESTPAT_EN
            ramp_q     <= ramp_d;
`endif
        end
    end

    assign bus.dac_a        = dac_a_q;
    assign bus.dac_b        = dac_b_q;
    assign bus.frame_d1     = frame_q;
    assign bus.frame_d2     = frame_q;
    assign bus.running      = running_q;
    assign bus.underrun_cnt = underrun_q;
endmodule
